// File: rtl/afifo_tb_pkg.sv
// Shared types and constants for the async FIFO read-side blocks.
// Data word type, read-drain FSM states, FIFO read latency.
package afifo_tb_pkg;

    typedef logic [7:0] data_t;
    typedef logic       bit_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_e;

    localparam int RD_LAT = 1;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry output buffer between the FIFO read port and the stream.
// Latency: a write is visible at head the cycle after it is written.
// Backpressure: the caller's credit check must keep writes off a full buffer.
module afifo_rd_skid
    import afifo_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  data_t       wr_dat,
    input  logic        rd,
    input  logic        flush,
    output data_t       head,
    output logic [1:0]  cnt
);

    data_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  wr_ok;
    logic  rd_ok;

    // A write into a full buffer is dropped unless a read frees a slot in the same cycle.
    assign wr_ok = wr && ((cnt != 2'd2) || rd);
    assign rd_ok = rd && (cnt != 2'd0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, wr_ok} - {1'b0, rd_ok};
        end
    end

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-domain consumer: pops the async FIFO and re-presents words as a valid/ready stream.
// Latency: first pop to m_valid is 2 cycles; sustained 1 word/cycle.
// Backpressure: pops are credit-limited so buffer plus in-flight never exceeds 2.
module afifo_rd_drain
    import afifo_tb_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    input  logic             en,
    input  logic             flush,
    input  logic             empty,
    output logic             pop,
    input  data_t            data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output data_t            m_data,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             busy
);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [RD_LAT-1:0] inflight_q;
    logic              inflight;
    logic [1:0]        buf_cnt;
    logic              hs;
    logic [2:0]        occ;

    assign inflight = inflight_q[RD_LAT-1];
    assign m_valid  = (buf_cnt != 2'd0);
    assign hs       = m_valid && m_ready;
    assign busy     = (state != RD_IDLE);

    // Occupancy after this cycle's handshake; hs implies buf_cnt >= 1 so no underflow.
    assign occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, hs};
    assign pop = (state == RD_RUN) && !empty && !flush && (occ < 3'(BUF_DEPTH));

    afifo_rd_skid u_skid (
        .clk    (rdclk),
        .rst    (rd_rst),
        .wr     (inflight && !flush),
        .wr_dat (data_out),
        .rd     (hs),
        .flush  (flush),
        .head   (m_data),
        .cnt    (buf_cnt)
    );

    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= RD_IDLE;
            inflight_q <= '0;
            xfer_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            inflight_q <= RD_LAT'(pop);
            if (hs) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (en) state_nxt = RD_RUN;
            end
            RD_RUN: begin
                if (!en) state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (en) begin
                    state_nxt = RD_RUN;
                end else if (buf_cnt == 2'd0 && !inflight) begin
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
        if (flush) begin
            state_nxt = en ? RD_RUN : RD_IDLE;
        end
    end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: FIFO emulation plus a queue-based scoreboard of popped words.
module tb_afifo_rd_drain;
    import afifo_tb_pkg::*;

    logic        rdclk = 1'b0;
    logic        rd_rst;
    logic        en;
    logic        flush;
    logic        empty;
    logic        pop;
    data_t       data_out;
    logic        m_valid;
    logic        m_ready;
    data_t       m_data;
    logic [15:0] xfer_cnt;
    logic        busy;

    afifo_rd_drain #(.CNT_W(16), .BUF_DEPTH(2)) dut (
        .rdclk    (rdclk),
        .rd_rst   (rd_rst),
        .en       (en),
        .flush    (flush),
        .empty    (empty),
        .pop      (pop),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .xfer_cnt (xfer_cnt),
        .busy     (busy)
    );

    always #5 rdclk = ~rdclk;

    int          n_cmp = 0;
    int          n_err = 0;

    data_t       fq[$];
    data_t       exp_q[$];
    int          age_q[$];
    int          cyc = 0;
    logic [15:0] cnt_m = '0;
    logic        en_prev = 1'b0;
    logic        busy_m = 1'b0;
    logic        prev_stall = 1'b0;
    data_t       prev_data = '0;
    logic        pop_s = 1'b0;
    data_t       nd = '0;

    always @(posedge rdclk) begin
        if (pop_s) data_out <= nd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        age_q.delete();
        fq.delete();
        cnt_m      = '0;
        en_prev    = 1'b0;
        busy_m     = 1'b0;
        prev_stall = 1'b0;
        pop_s      = 1'b0;
    endtask

    task automatic monitor();
        logic hs;
        int   out_n;
        logic exp_pop;
        logic busy_nxt;
        hs      = m_valid && m_ready;
        out_n   = exp_q.size();
        exp_pop = en_prev && !empty && !flush && ((out_n - int'(hs)) < 2);
        chk("pop", {31'd0, pop}, {31'd0, exp_pop});
        chk("m_valid", {31'd0, m_valid}, {31'd0, (out_n > 0) && (cyc - age_q[0] >= 2)});
        chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_m});
        chk("busy", {31'd0, busy}, {31'd0, busy_m});
        if (prev_stall) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        if (hs && out_n > 0) begin
            chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
        end
        busy_nxt = en ? 1'b1 : (flush ? 1'b0 : (en_prev ? 1'b1 : (busy_m && out_n != 0)));
        if (hs) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(age_q.pop_front());
            end
            cnt_m = cnt_m + 16'd1;
        end
        if (flush) begin
            exp_q.delete();
            age_q.delete();
        end
        pop_s = pop;
        if (pop && fq.size() > 0) begin
            nd = fq.pop_front();
            exp_q.push_back(nd);
            age_q.push_back(cyc);
        end
        prev_stall = m_valid && !m_ready && !flush;
        prev_data  = m_data;
        en_prev    = en;
        busy_m     = busy_nxt;
        cyc++;
    endtask

    task automatic tick(input logic en_i, input logic fl_i, input logic rdy_i);
        @(negedge rdclk);
        en      = en_i;
        flush   = fl_i;
        m_ready = rdy_i;
        empty   = (fq.size() == 0);
        #2;
        monitor();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) fq.push_back(data_t'($urandom));
    endtask

    initial begin
        rd_rst   = 1'b1;
        en       = 1'b0;
        flush    = 1'b0;
        empty    = 1'b1;
        m_ready  = 1'b0;
        data_out = '0;
        #3;
        chk("rst_pop", {31'd0, pop}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge rdclk);
        rd_rst = 1'b0;

        // Three known words streamed straight through.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
        chk("t1_cnt", {16'd0, xfer_cnt}, 32'd3);

        // Stalled sink: only two credits worth of pops, then full delivery.
        push_n(4);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
        chk("t2_cnt", {16'd0, xfer_cnt}, 32'd7);

        // Stop-and-drain.
        push_n(5);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        fq.delete();

        // Flush while stalled and full, then flush mid-stream.
        push_n(6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
        push_n(6);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) push_n(int'($urandom_range(1, 3)));
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset between edges.
        push_n(6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
        #1 rd_rst = 1'b1;
        #1;
        chk("arst_pop", {31'd0, pop}, 32'd0);
        chk("arst_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cnt", {16'd0, xfer_cnt}, 32'd0);
        model_clear();
        @(negedge rdclk);
        @(negedge rdclk);
        rd_rst = 1'b0;
        en     = 1'b0;

        // Counter wrap at 2^16.
        for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) begin
            if (fq.size() < 4) push_n(4);
            tick(1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 8 && cnt_m != 16'h0000; i++) begin
            if (fq.size() < 4) push_n(4);
            tick(1'b1, 1'b0, 1'b1);
        end
        @(posedge rdclk);
        #1;
        chk("wrap", {16'd0, xfer_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
